// File: rtl/sub_16bit_serial_pkg.sv
// rtl/sub_16bit_serial_pkg.sv - shared slice width and sequencer state encoding
package sub_16bit_serial_pkg;

    localparam int CLA_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/CLA_4bit.sv
// rtl/CLA_4bit.sv - 4-bit carry-lookahead adder slice
module CLA_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is flattened to generate/propagate terms of the slice inputs.
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);

    assign sum_o = p ^ c[3:0];
    assign c_o   = c[4];

endmodule

// File: rtl/sub_16bit_serial.sv
// rtl/sub_16bit_serial.sv - nibble-serial subtractor reusing one CLA slice per cycle
module sub_16bit_serial
    import sub_16bit_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = CLA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [SLICE-1:0] sum_s;
    logic             cout_s;

    // Subtraction as a + ~b + ~borrow_in: carry-out 1 means no borrow.
    CLA_4bit u_cla (
        .a_i   (a_q[cnt_q*SLICE +: SLICE]),
        .b_i   (nb_q[cnt_q*SLICE +: SLICE]),
        .c_i   (c_q),
        .sum_o (sum_s),
        .c_o   (cout_s)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = in1;
                    nb_d    = ~in2;
                    c_d     = ~b_in;
                    cnt_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                diff_d[cnt_q*SLICE +: SLICE] = sum_s;
                c_d   = cout_s;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NSL - 1)) begin
                    bout_d  = ~cout_s;
                    ovf_d   = (a_q[MSB] ^ ~nb_q[MSB]) & (a_q[MSB] ^ diff_d[MSB]);
                    zero_d  = (diff_d == '0);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign b_out    = bout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_sub_16bit_serial.sv
// tb/tb_sub_16bit_serial.sv - directed and held-start checks for sub_16bit_serial
module tb_sub_16bit_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        b_in;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        b_out;
    logic        overflow;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    sub_16bit_serial #(.WIDTH(16), .SLICE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in1      (in1),
        .in2      (in2),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .b_out    (b_out),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_done"}, 16'(done), 16'd0);
        chk({tag, "_diff"}, diff, 16'h0000);
        chk({tag, "_bout"}, 16'(b_out), 16'd0);
        chk({tag, "_ovf"}, 16'(overflow), 16'd0);
        chk({tag, "_zero"}, 16'(zero), 16'd0);
    endtask

    task automatic chk_res(input string tag, input logic [15:0] ed,
                           input logic eb, input logic eo, input logic ez);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bout"}, 16'(b_out), 16'(eb));
        chk({tag, "_ovf"}, 16'(overflow), 16'(eo));
        chk({tag, "_zero"}, 16'(zero), 16'(ez));
    endtask

    // Called at a negedge in IDLE; returns at the negedge after E5.
    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic bi, input logic [15:0] ed,
                          input logic eb, input logic eo, input logic ez);
        in1 = x; in2 = y; b_in = bi; start = 1'b1;
        step();
        start = 1'b0; in1 = ~x; in2 = 16'h5555 ^ y; b_in = ~bi;
        chk({tag, "_busy_e0"}, 16'(busy), 16'd1);
        chk({tag, "_done_e0"}, 16'(done), 16'd0);
        repeat (3) step();
        chk({tag, "_done_e3"}, 16'(done), 16'd0);
        step();
        chk({tag, "_done_e4"}, 16'(done), 16'd1);
        chk({tag, "_busy_e4"}, 16'(busy), 16'd1);
        chk_res(tag, ed, eb, eo, ez);
        step();
        chk({tag, "_done_e5"}, 16'(done), 16'd0);
        chk({tag, "_busy_e5"}, 16'(busy), 16'd0);
        chk({tag, "_hold"}, diff, ed);
    endtask

    initial begin
        logic [15:0] ra, rb, rd;
        logic        rbi, rbo, ro;
        logic [16:0] wide;
        int          done_seen;

        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; b_in = 1'b0;
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("post_reset");

        run_op("basic",    16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("underflow",16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("ovf_pos",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("ovf_neg",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_op("eq_zero",  16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_op("eq_bin",   16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // start pulsed with new operands at E2 must not disturb the operation in flight
        in1 = 16'h1234; in2 = 16'h0234; b_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        in1 = 16'hFFFF; in2 = 16'h0001; b_in = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("ignore_done", 16'(done), 16'd1);
        chk_res("ignore", 16'h1000, 1'b0, 1'b0, 1'b0);
        step();
        chk("ignore_idle", 16'(busy), 16'd0);

        // reset mid-RUN
        in1 = 16'h4321; in2 = 16'h1111; b_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("midrun_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        chk("midrun_no_done", 16'(done_seen), 16'd0);
        run_op("after_rst", 16'hFFFF, 16'h0001, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);

        // start held high: accept every 6 cycles, operands churn every cycle
        for (int k = 0; k < 200; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom);
            if (k == 0) begin ra = 16'h0000; rb = 16'h0000; rbi = 1'b0; end
            in1 = ra; in2 = rb; b_in = rbi; start = 1'b1;
            wide = {1'b0, ra} - {1'b0, rb} - {16'd0, rbi};
            rd   = wide[15:0];
            rbo  = wide[16];
            ro   = (ra[15] ^ rb[15]) & (ra[15] ^ rd[15]);
            for (int t = 0; t < 6; t++) begin
                step();
                in1 = 16'($urandom); in2 = 16'($urandom); b_in = 1'($urandom);
                chk("held_done", 16'(done), (t == 4) ? 16'd1 : 16'd0);
                if (t == 4) chk_res("held", rd, rbo, ro, (rd == 16'h0000));
            end
        end
        start = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sub_16bit_serial.md
# sub_16bit_serial

Nibble-serial 16-bit subtractor: the inverse operation to the team's 16-bit cascaded-CLA adder. It computes `in1 - in2 - b_in` over four clock cycles, one 4-bit slice per cycle, by feeding a single `CLA_4bit` with the inverted subtrahend and the inverted borrow as carry-in. It sits beside the adder in the ALU datapath. It trades latency for one reused 4-bit CLA and adds a start/done handshake plus status flags.

## Interface
- `WIDTH`, default 16: operand width. Must be a multiple of `SLICE`.
- `SLICE`, default 4: bits processed per cycle, matching the `CLA_4bit` width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: request. Sampled only in IDLE.
- `in1`  in  WIDTH: minuend. Sampled on the accepting edge.
- `in2`  in  WIDTH: subtrahend. Sampled on the accepting edge.
- `b_in`  in  1: borrow-in. Sampled on the accepting edge.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse. Results are valid from this cycle onward.
- `diff`  out  WIDTH: `in1 - in2 - b_in`, modulo 2^WIDTH.
- `b_out`  out  1: unsigned borrow, i.e. `in1 < in2 + b_in`.
- `overflow`  out  1: two's-complement overflow of the subtraction.
- `zero`  out  1: `diff == 0`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:** on `start = 1`:
  - latch `a = in1`, `nb = ~in2`, `c = ~b_in`;
  - set slice counter `cnt = 0`;
  - go to RUN.
- **RUN, each edge:**
  - `CLA_4bit(a[slice cnt], nb[slice cnt], c)` writes sum into `diff[slice cnt]`;
  - `c` takes that slice's carry-out;
  - `cnt` increments.
- **Last slice** (`cnt == WIDTH/SLICE - 1`), on the same edge:
  - `b_out = ~carry_out`;
  - `overflow = (a[MSB] ^ ~nb[MSB]) & (a[MSB] ^ diff_new[MSB])`;
  - `zero = (full new diff == 0)`;
  - go to DONE.
- **DONE:** `done = 1` for exactly one cycle, then IDLE unconditionally.
- **`start` outside IDLE:** ignored. No queueing, no effect on the operation in flight.
- **Holding:** `diff` and the flags hold their values until the next accepted `start`.
- **Clearing:** on acceptance, `diff` and the flags clear to 0 and are rebuilt slice by slice. Partially built `diff` is visible while busy and is not valid.
- **Reset:**
  - All outputs and internal registers reset to 0; state goes to IDLE.
  - Reset mid-RUN aborts the operation and produces no `done`.
- **Latched operands:** input changes after acceptance have no effect.
- **Arithmetic:**
  - modular at WIDTH;
  - borrow chain is carry-inverted (carry = 1 means no borrow);
  - `b_in = 1` subtracts one more.

## Timing
- Edge E0: `start` accepted; `busy` = 1 after E0.
- Edges E1–E4: slices 0–3, least-significant first.
- After E4: `done` = 1 and results are final.
- After E5: `done` = 0, `busy` = 0, state is IDLE.
- Earliest next acceptance is E6, giving a throughput of 1 operation per 6 cycles with `start` held high.
- Latency from the accepting edge to `done` is `WIDTH/SLICE` cycles (4 at defaults).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Shared package/include:** state encoding (IDLE/RUN/DONE localparams) and the `SLICE` width constant, shared with the adder blocks.
- **Sub-module:** exactly one instance of the existing `CLA_4bit`. No new sub-module.
- **Slice selection:** indexed part-select on `cnt`. `cnt` width is `$clog2(WIDTH/SLICE)`.

## Test plan
- `in1 = 0x1234`, `in2 = 0x0234`, `b_in = 0`, start pulse → `done` 4 cycles after acceptance; `diff = 0x1000`, `b_out = 0`, `overflow = 0`, `zero = 0`.
- `0x0000 - 0x0001`, `b_in = 0` → `diff = 0xFFFF`, `b_out = 1`, `overflow = 0`.
- `0x8000 - 0x0001` → `diff = 0x7FFF`, `overflow = 1`, `b_out = 0`. Also `0x7FFF - 0xFFFF` → `diff = 0x8000`, `overflow = 1`, `b_out = 1`.
- `0x5A5A - 0x5A5A`:
  - with `b_in = 0` → `diff = 0`, `zero = 1`;
  - with `b_in = 1` → `diff = 0xFFFF`, `b_out = 1`, `zero = 0`.
- Pulse `start` with new operands at E2 while busy → ignored; the original result is delivered unchanged at E4. Then assert `rst` mid-RUN → all outputs 0 immediately, no `done`; the next start after release completes normally.
- Hold `start` high with random operands for 200 operations → one `done` per 6 cycles; every result matches the reference model (diff, `b_out`, `overflow`, `zero`).
